// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data memory responder with programmable wait states
// Latches one load/store request, waits LATENCY cycles, then commits and pulses ready.

module data_mem_responder #(
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        ready,
   output logic        busy,
   output logic        misaligned
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAT   = 4'(LATENCY);
   localparam int         DEPTH = 1 << ADDR_WIDTH;

   logic [31:0]           r_mem [DEPTH];
   state_t                r_state;
   logic [3:0]            r_cnt;
   logic                  r_is_write;
   logic [ADDR_WIDTH+1:0] r_addr;
   logic [31:0]           r_wdata;

   logic                  w_req;
   logic                  w_from_idle;
   logic                  w_from_wait;
   logic                  w_commit;
   logic                  w_c_write;
   logic [ADDR_WIDTH+1:0] w_c_addr;
   logic [31:0]           w_c_wdata;
   logic                  w_c_mis;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic                  w_unused_addr;

   assign w_req         = MemRead | MemWrite;
   assign w_unused_addr = &{1'b0, address[31:ADDR_WIDTH+2]};

   // With zero latency the commit happens on the accepting edge, so the
   // operands come straight from the inputs instead of the latches.
   assign w_from_idle = (r_state == S_IDLE) && w_req && (LAT == 4'd0);
   assign w_from_wait = (r_state == S_WAIT) && (r_cnt == 4'd1);
   assign w_commit    = w_from_idle | w_from_wait;
   assign w_c_write   = w_from_idle ? MemWrite : r_is_write;
   assign w_c_addr    = w_from_idle ? address[ADDR_WIDTH+1:0] : r_addr;
   assign w_c_wdata   = w_from_idle ? writeData : r_wdata;
   assign w_c_mis     = |w_c_addr[1:0];
   assign w_idx       = w_c_addr[ADDR_WIDTH+1:2];

   // Memory contents survive reset; rst only blocks a commit on the same edge.
   always_ff @(posedge clk) begin
      if (!rst && w_commit && w_c_write && !w_c_mis)
         r_mem[w_idx] <= w_c_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_is_write <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= 32'd0;
         readData   <= 32'd0;
         ready      <= 1'b0;
         busy       <= 1'b0;
         misaligned <= 1'b0;
      end else begin
         ready      <= 1'b0;
         misaligned <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_is_write <= MemWrite;
                  r_addr     <= address[ADDR_WIDTH+1:0];
                  r_wdata    <= writeData;
                  r_cnt      <= LAT;
                  busy       <= 1'b1;
                  r_state    <= (LAT == 4'd0) ? S_DONE : S_WAIT;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1)
                  r_state <= S_DONE;
            end
            S_DONE: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
         if (w_commit) begin
            ready      <= 1'b1;
            misaligned <= w_c_mis;
            if (w_c_mis)
               readData <= 32'd0;
            else if (!w_c_write)
               readData <= r_mem[w_idx];
         end
      end
   end

endmodule
